// File: rtl/fmp_pkg.sv
// Shared types and helpers for the multi-point blob locator.
// Coordinate width and match distance are fixed here and used by every fmp_* module.
`timescale 1ns/1ps
package fmp_pkg;

  localparam int W     = 16;
  localparam int DIST  = 2;
  localparam int N_PTS = 4;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] min_h;
    logic [W-1:0] max_h;
    logic [W-1:0] min_v;
    logic [W-1:0] max_v;
  } box_t;

  // Midpoint of two coordinates; the sum carries one extra bit so it cannot wrap.
  function automatic logic [W-1:0] centre(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W:1];
  endfunction

  function automatic logic [N_PTS-1:0] lowest_one(input logic [N_PTS-1:0] x);
    return x & (~x + N_PTS'(1));
  endfunction

  function automatic logic [W-1:0] popcount(input logic [N_PTS-1:0] x);
    logic [W-1:0] n;
    n = '0;
    for (int i = 0; i < N_PTS; i++) begin
      n = n + W'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fmp_cluster.sv
// One point cluster: holds a bounding box, flags whether the current pixel is close
// enough to join it, and grows or opens the box when the top level says so.
`timescale 1ns/1ps
module fmp_cluster
  import fmp_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         grant_i,
  input  logic         open_i,
  input  logic [W-1:0] h_i,
  input  logic [W-1:0] v_i,
  output logic         match_o,
  output logic         valid_o,
  output logic [W-1:0] centre_h_o,
  output logic [W-1:0] centre_v_o
);

  box_t       box_q, box_d;
  logic [W:0] lo_h_s, hi_h_s, hi_v_s;

  // Match window; upper bounds use W+1 bits so a box at the top of the range never wraps.
  always_comb begin
    if ({1'b0, box_q.min_h} >= (W+1)'(DIST)) begin
      lo_h_s = {1'b0, box_q.min_h} - (W+1)'(DIST);
    end else begin
      lo_h_s = '0;
    end
    hi_h_s  = {1'b0, box_q.max_h} + (W+1)'(DIST);
    hi_v_s  = {1'b0, box_q.max_v} + (W+1)'(DIST);
    match_o = box_q.valid
            & ({1'b0, h_i} >= lo_h_s)
            & ({1'b0, h_i} <= hi_h_s)
            & ({1'b0, v_i} <= hi_v_s);
  end

  // Box next state: opening beats growing beats the frame-start clear.
  always_comb begin
    box_d = box_q;
    if (open_i) begin
      box_d.valid = 1'b1;
      box_d.min_h = h_i;
      box_d.max_h = h_i;
      box_d.min_v = v_i;
      box_d.max_v = v_i;
    end else if (grant_i) begin
      box_d.min_h = (h_i < box_q.min_h) ? h_i : box_q.min_h;
      box_d.max_h = (h_i > box_q.max_h) ? h_i : box_q.max_h;
      box_d.max_v = (v_i > box_q.max_v) ? v_i : box_q.max_v;
    end else if (clear_i) begin
      box_d = '0;
    end else begin
      box_d = box_q;
    end
  end

  // Box register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      box_q <= '0;
    end else begin
      box_q <= box_d;
    end
  end

  assign valid_o    = box_q.valid;
  assign centre_h_o = centre(box_q.min_h, box_q.max_h);
  assign centre_v_o = centre(box_q.min_v, box_q.max_v);

endmodule

// File: rtl/find_multi_points.sv
// Streaming blob locator: groups white pixels of a frame into up to four clusters and
// publishes their centres, valid mask, count and a pixel-count/overflow word at frame end.
`timescale 1ns/1ps
module find_multi_points
  import fmp_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         VGA_HS,
  input  logic         VGA_VS,
  input  logic         BINARY_FLAG,
  input  logic [W-1:0] H_CNT,
  input  logic [W-1:0] V_CNT,
  output logic [W-1:0] o_POINTS_H_0,
  output logic [W-1:0] o_POINTS_V_0,
  output logic [W-1:0] o_POINTS_H_1,
  output logic [W-1:0] o_POINTS_V_1,
  output logic [W-1:0] o_POINTS_H_2,
  output logic [W-1:0] o_POINTS_V_2,
  output logic [W-1:0] o_POINTS_H_3,
  output logic [W-1:0] o_POINTS_V_3,
  output logic [W-1:0] o_POINTS_GROUP,
  output logic [W-1:0] o_POINTS_NUM,
  output logic [W-1:0] test
);

  logic vs_q, vs_d;
  logic armed_q, armed_d;
  logic in_frame_q, in_frame_d;
  logic pub_q, pub_d;
  logic [W-2:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;

  logic rise_s, fall_s, pix_s, ovf_hit_s;
  logic [N_PTS-1:0] match_raw_s, match_s, valid_s, free_s, grant_s, open_s;
  logic [W-1:0] cen_h_s [N_PTS];
  logic [W-1:0] cen_v_s [N_PTS];

  logic [W-1:0] pts_h_q [N_PTS];
  logic [W-1:0] pts_v_q [N_PTS];
  logic [W-1:0] group_q, num_q, test_q;

  for (genvar k = 0; k < N_PTS; k++) begin : g_clu
    fmp_cluster u_clu (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .clear_i    (rise_s),
      .grant_i    (grant_s[k]),
      .open_i     (open_s[k]),
      .h_i        (H_CNT),
      .v_i        (V_CNT),
      .match_o    (match_raw_s[k]),
      .valid_o    (valid_s[k]),
      .centre_h_o (cen_h_s[k]),
      .centre_v_o (cen_v_s[k])
    );
  end

  // Frame tracking: after reset nothing is accumulated until VS has been seen low and
  // then rises, so a frame interrupted by reset is never reported.
  always_comb begin
    armed_d    = armed_q | ~VGA_VS;
    vs_d       = VGA_VS;
    rise_s     = VGA_VS & ~vs_q & armed_q;
    fall_s     = ~VGA_VS & vs_q & in_frame_q;
    pub_d      = fall_s;
    in_frame_d = in_frame_q;
    if (rise_s) begin
      in_frame_d = 1'b1;
    end else if (fall_s) begin
      in_frame_d = 1'b0;
    end else begin
      in_frame_d = in_frame_q;
    end
    pix_s = VGA_VS & VGA_HS & BINARY_FLAG & (in_frame_q | rise_s);
  end

  // Grants: lowest matching cluster grows; otherwise lowest free cluster opens.
  always_comb begin
    match_s   = match_raw_s & {N_PTS{pix_s & ~rise_s}};
    free_s    = rise_s ? {N_PTS{1'b1}} : ~valid_s;
    grant_s   = lowest_one(match_s);
    open_s    = '0;
    ovf_hit_s = 1'b0;
    if (pix_s && (match_s == '0)) begin
      open_s    = lowest_one(free_s);
      ovf_hit_s = (free_s == '0);
    end else begin
      open_s    = '0;
      ovf_hit_s = 1'b0;
    end
  end

  // Saturating white-pixel counter and overflow flag, both restarted at frame start.
  always_comb begin
    cnt_d = rise_s ? '0 : cnt_q;
    ovf_d = rise_s ? 1'b0 : ovf_q;
    if (pix_s && (cnt_d != {(W-1){1'b1}})) begin
      cnt_d = cnt_d + (W-1)'(1);
    end else begin
      cnt_d = cnt_d;
    end
    if (ovf_hit_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // Control and accumulator registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vs_q       <= 1'b0;
      armed_q    <= 1'b0;
      in_frame_q <= 1'b0;
      pub_q      <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vs_q       <= vs_d;
      armed_q    <= armed_d;
      in_frame_q <= in_frame_d;
      pub_q      <= pub_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Output registers, loaded one cycle after the frame end is seen.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < N_PTS; k++) begin
        pts_h_q[k] <= '0;
        pts_v_q[k] <= '0;
      end
      group_q <= '0;
      num_q   <= '0;
      test_q  <= '0;
    end else if (pub_q) begin
      for (int k = 0; k < N_PTS; k++) begin
        pts_h_q[k] <= valid_s[k] ? cen_h_s[k] : '0;
        pts_v_q[k] <= valid_s[k] ? cen_v_s[k] : '0;
      end
      group_q <= {{(W-N_PTS){1'b0}}, valid_s};
      num_q   <= popcount(valid_s);
      test_q  <= {ovf_q, cnt_q};
    end
  end

  assign o_POINTS_H_0   = pts_h_q[0];
  assign o_POINTS_V_0   = pts_v_q[0];
  assign o_POINTS_H_1   = pts_h_q[1];
  assign o_POINTS_V_1   = pts_v_q[1];
  assign o_POINTS_H_2   = pts_h_q[2];
  assign o_POINTS_V_2   = pts_v_q[2];
  assign o_POINTS_H_3   = pts_h_q[3];
  assign o_POINTS_V_3   = pts_v_q[3];
  assign o_POINTS_GROUP = group_q;
  assign o_POINTS_NUM   = num_q;
  assign test           = test_q;

endmodule

// File: tb/tb_find_multi_points.sv
// Bench for find_multi_points: 10x10 frames, directed and random, against a frame-level
// clustering model that replays the frame's white pixels in raster order.
`timescale 1ns/1ps
module tb_find_multi_points;

  localparam int DIST = 2;

  logic        CLK = 1'b0;
  logic        RST_N, VGA_HS, VGA_VS, BINARY_FLAG;
  logic [15:0] H_CNT, V_CNT;
  logic [15:0] h0, v0, h1, v1, h2, v2, h3, v3, grp, num, tst;

  always #50 CLK = ~CLK;

  find_multi_points dut (
    .CLK(CLK), .RST_N(RST_N), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .BINARY_FLAG(BINARY_FLAG),
    .H_CNT(H_CNT), .V_CNT(V_CNT),
    .o_POINTS_H_0(h0), .o_POINTS_V_0(v0), .o_POINTS_H_1(h1), .o_POINTS_V_1(v1),
    .o_POINTS_H_2(h2), .o_POINTS_V_2(v2), .o_POINTS_H_3(h3), .o_POINTS_V_3(v3),
    .o_POINTS_GROUP(grp), .o_POINTS_NUM(num), .test(tst)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit track  = 1'b0;
  bit img [10][10];
  int qh[$];
  int qv[$];
  logic [15:0] exp_h [4];
  logic [15:0] exp_v [4];
  logic [15:0] exp_group, exp_num, exp_test;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic zero_exp();
    for (int k = 0; k < 4; k++) begin
      exp_h[k] = 16'd0;
      exp_v[k] = 16'd0;
    end
    exp_group = 16'd0;
    exp_num   = 16'd0;
    exp_test  = 16'd0;
  endtask

  // Frame-level model: walk the white pixels in arrival order and cluster them.
  task automatic compute_expected();
    int vld[4], mnh[4], mxh[4], mnv[4], mxv[4];
    int n, win, lo;
    bit ovf;
    n = 0;
    ovf = 1'b0;
    for (int k = 0; k < 4; k++) vld[k] = 0;
    for (int i = 0; i < qh.size(); i++) begin
      win = -1;
      for (int k = 0; k < 4; k++) begin
        lo = (mnh[k] - DIST < 0) ? 0 : mnh[k] - DIST;
        if (win < 0 && vld[k] != 0 && qh[i] >= lo && qh[i] <= mxh[k] + DIST
            && qv[i] <= mxv[k] + DIST) win = k;
      end
      if (win >= 0) begin
        if (qh[i] < mnh[win]) mnh[win] = qh[i];
        if (qh[i] > mxh[win]) mxh[win] = qh[i];
        if (qv[i] > mxv[win]) mxv[win] = qv[i];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (win < 0 && vld[k] == 0) begin
            win = k;
            vld[k] = 1;
            mnh[k] = qh[i]; mxh[k] = qh[i];
            mnv[k] = qv[i]; mxv[k] = qv[i];
          end
        end
        if (win < 0) ovf = 1'b1;
      end
      n++;
    end
    exp_group = 16'd0;
    exp_num   = 16'd0;
    for (int k = 0; k < 4; k++) begin
      exp_h[k] = (vld[k] != 0) ? 16'((mnh[k] + mxh[k]) / 2) : 16'd0;
      exp_v[k] = (vld[k] != 0) ? 16'((mnv[k] + mxv[k]) / 2) : 16'd0;
      if (vld[k] != 0) begin
        exp_group = exp_group | (16'd1 << k);
        exp_num   = exp_num + 16'd1;
      end
    end
    exp_test = {ovf, 15'((n > 32767) ? 32767 : n)};
  endtask

  // Continuous comparison of every output against the current expectation.
  always @(negedge CLK) begin
    if (chk_en) begin
      cmp("H0", h0, exp_h[0]); cmp("V0", v0, exp_v[0]);
      cmp("H1", h1, exp_h[1]); cmp("V1", v1, exp_v[1]);
      cmp("H2", h2, exp_h[2]); cmp("V2", v2, exp_v[2]);
      cmp("H3", h3, exp_h[3]); cmp("V3", v3, exp_v[3]);
      cmp("GROUP", grp, exp_group);
      cmp("NUM", num, exp_num);
      cmp("TEST", tst, exp_test);
    end
  end

  task automatic cyc(input logic vs, input logic hs, input logic bf, input int h, input int v);
    VGA_VS = vs; VGA_HS = hs; BINARY_FLAG = bf;
    H_CNT = 16'(h); V_CNT = 16'(v);
    if (vs && hs && bf && track) begin
      qh.push_back(h);
      qv.push_back(v);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_img();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) img[r][c] = 1'b0;
  endtask

  function automatic logic rbit(input bit noisy);
    return noisy ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // One frame: HS low for a cycle before each line; optional reset at pixel index rst_at.
  task automatic run_frame(input bit noisy, input int rst_at, input int hoff, input int voff);
    qh.delete();
    qv.delete();
    track = 1'b1;
    for (int r = 0; r < 10; r++) begin
      cyc(1'b1, 1'b0, rbit(noisy), int'($urandom_range(0, 65535)), voff + r);
      for (int c = 0; c < 10; c++) begin
        if (r * 10 + c == rst_at) begin
          RST_N = 1'b0;
          zero_exp();
          track = 1'b0;
          qh.delete();
          qv.delete();
          #1;
          cmp("rst_group_now", grp, 16'd0);
          cmp("rst_h0_now", h0, 16'd0);
        end
        cyc(1'b1, 1'b1, img[r][c], hoff + c, voff + r);
        RST_N = 1'b1;
      end
    end
    cyc(1'b0, rbit(noisy), rbit(noisy), int'($urandom_range(0, 65535)), 0);
    cyc(1'b0, rbit(noisy), rbit(noisy), int'($urandom_range(0, 65535)), 0);
    if (track) compute_expected();
    for (int i = 0; i < 3; i++) cyc(1'b0, rbit(noisy), rbit(noisy), 0, 0);
  endtask

  initial begin
    int hoff, voff, dens;
    RST_N = 1'b0;
    zero_exp();
    VGA_VS = 1'b0; VGA_HS = 1'b0; BINARY_FLAG = 1'b0; H_CNT = 16'd0; V_CNT = 16'd0;
    chk_en = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 0, 0);
    RST_N = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 0, 0);

    clear_img(); img[2][3] = 1'b1;
    run_frame(1'b0, -1, 0, 0);
    cmp("single_num", num, 16'd1); cmp("single_group", grp, 16'h0001);
    cmp("single_h0", h0, 16'd3);   cmp("single_v0", v0, 16'd2);
    cmp("single_test", tst, 16'h0001); cmp("single_h1", h1, 16'd0);

    clear_img();
    img[1][1] = 1'b1; img[1][2] = 1'b1; img[2][1] = 1'b1; img[2][2] = 1'b1;
    img[6][6] = 1'b1; img[6][7] = 1'b1; img[7][6] = 1'b1; img[7][7] = 1'b1;
    run_frame(1'b0, -1, 0, 0);
    cmp("blob_num", num, 16'd2); cmp("blob_group", grp, 16'h0003);
    cmp("blob_h0", h0, 16'd1); cmp("blob_v0", v0, 16'd1);
    cmp("blob_h1", h1, 16'd6); cmp("blob_v1", v1, 16'd6);
    cmp("blob_test", tst, 16'd8);

    clear_img();
    img[0][0] = 1'b1; img[0][9] = 1'b1; img[9][0] = 1'b1; img[9][9] = 1'b1; img[5][5] = 1'b1;
    run_frame(1'b0, -1, 0, 0);
    cmp("five_num", num, 16'd4); cmp("five_group", grp, 16'h000F);
    cmp("five_test", tst, 16'h8005);

    clear_img();
    for (int r = 0; r < 10; r++) img[r][4] = 1'b1;
    run_frame(1'b0, -1, 0, 0);
    cmp("bar_num", num, 16'd1); cmp("bar_h0", h0, 16'd4); cmp("bar_v0", v0, 16'd4);

    clear_img();
    run_frame(1'b1, -1, 0, 0);
    cmp("black_num", num, 16'd0); cmp("black_group", grp, 16'd0); cmp("black_test", tst, 16'd0);

    clear_img();
    img[1][1] = 1'b1; img[6][6] = 1'b1;
    run_frame(1'b0, -1, 0, 0);
    img[7][7] = 1'b1;
    run_frame(1'b0, 45, 0, 0);
    cmp("rst_frame_num", num, 16'd0);
    run_frame(1'b0, -1, 0, 0);
    cmp("after_rst_num", num, 16'd2); cmp("after_rst_h1", h1, 16'd6);

    for (int f = 0; f < 24; f++) begin
      case (f % 3)
        0: begin hoff = 0; voff = 0; end
        1: begin hoff = 65526; voff = 65526; end
        default: begin hoff = int'($urandom_range(0, 65526)); voff = int'($urandom_range(0, 65526)); end
      endcase
      dens = (f % 2 == 0) ? 6 : 35;
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++) img[r][c] = ($urandom_range(0, 99) < dens);
      run_frame(f % 4 == 3, (f == 10) ? int'($urandom_range(0, 99)) : -1, hoff, voff);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
